// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: per-stage hold vector, multi-cycle EX sequencing,
// exception flush windows with redirect PC, and a sticky stall watchdog.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_done,
    output logic             busy,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam int          WD_W      = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_TRIP   = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      FCNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       fcnt;
    logic [WD_W-1:0]  wd;
    logic             any_req;
    logic [CNT_W-1:0] mc_len_m1;

    assign any_req   = stallreq_id | stallreq_ex;
    // A zero-length op is run as a single-cycle op.
    assign mc_len_m1 = (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (flush_req) begin
            next_state = FLUSH;
        end else begin
            case (state)
                RUN:     if (ex_mc_start) next_state = MC_WAIT;
                MC_WAIT: if (cnt == '0)   next_state = RUN;
                FLUSH:   if (fcnt == '0)  next_state = RUN;
                default: next_state = RUN;
            endcase
        end
    end

    always_comb begin
        stall = 6'b000000;
        busy  = (state != RUN);
        if (!rst) begin
            case (state)
                RUN: begin
                    if (stallreq_ex)      stall = 6'b001111;
                    else if (stallreq_id) stall = 6'b000111;
                end
                MC_WAIT: stall = 6'b001111;
                default: stall = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            fcnt          <= '0;
            wd            <= '0;
            flush         <= 1'b0;
            new_pc        <= ZERO_WORD;
            mc_done       <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            mc_done <= 1'b0;
            if (flush_req) begin
                // Also aborts any multi-cycle op in flight, suppressing its done pulse.
                fcnt   <= FCNT_INIT;
                flush  <= 1'b1;
                new_pc <= flush_pc;
                cnt    <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (ex_mc_start) begin
                            cnt     <= mc_len_m1;
                            mc_done <= (mc_len_m1 == '0);
                        end
                    end
                    MC_WAIT: begin
                        if (cnt != '0) begin
                            cnt     <= cnt - CNT_W'(1);
                            mc_done <= (cnt == CNT_W'(1));
                        end
                    end
                    FLUSH: begin
                        if (fcnt == '0) flush <= 1'b0;
                        else            fcnt  <= fcnt - 4'd1;
                    end
                    default: ;
                endcase
            end

            if (state == RUN && next_state == RUN && any_req)
                wd <= (wd == WD_MAX) ? wd : wd + WD_W'(1);
            else
                wd <= '0;

            if (state == RUN && any_req && wd == WD_TRIP)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: one instance with default parameters,
// one with FLUSH_CYCLES=3 / TIMEOUT=4, both driven from the same stimulus.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_cycles;
    logic             flush_req;
    logic [31:0]      flush_pc;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        mc_done_a, mc_done_b;
    logic        busy_a, busy_b;
    logic        tmo_a, tmo_b;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        mc_done;
        logic        busy;
        logic        tmo;
    } exp_t;

    exp_t sb[$];

    pipe_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(255), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
        .mc_done(mc_done_a), .busy(busy_a), .stall_timeout(tmo_a)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(4), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
        .mc_done(mc_done_b), .busy(busy_b), .stall_timeout(tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic id, input logic ex, input logic mcs,
                         input logic [CNT_W-1:0] mcn, input logic fr, input logic [31:0] fpc);
        rst          = r;
        stallreq_id  = id;
        stallreq_ex  = ex;
        ex_mc_start  = mcs;
        ex_mc_cycles = mcn;
        flush_req    = fr;
        flush_pc     = fpc;
    endtask

    // Push the expectation for the current cycle, compare mid-cycle, then advance one edge.
    task automatic cyc(input string tag, input int sel, input logic [5:0] s, input logic f,
                       input logic [31:0] pc, input logic d, input logic b, input logic t);
        exp_t e;
        exp_t g;
        e.tag = tag; e.sel = sel; e.stall = s; e.flush = f;
        e.new_pc = pc; e.mc_done = d; e.busy = b; e.tmo = t;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        if (g.sel == 0) begin
            chk({g.tag, ".stall"},   32'(stall_a),   32'(g.stall));
            chk({g.tag, ".flush"},   32'(flush_a),   32'(g.flush));
            chk({g.tag, ".new_pc"},  new_pc_a,       g.new_pc);
            chk({g.tag, ".mc_done"}, 32'(mc_done_a), 32'(g.mc_done));
            chk({g.tag, ".busy"},    32'(busy_a),    32'(g.busy));
            chk({g.tag, ".timeout"}, 32'(tmo_a),     32'(g.tmo));
        end else begin
            chk({g.tag, ".stall"},   32'(stall_b),   32'(g.stall));
            chk({g.tag, ".flush"},   32'(flush_b),   32'(g.flush));
            chk({g.tag, ".new_pc"},  new_pc_b,       g.new_pc);
            chk({g.tag, ".mc_done"}, 32'(mc_done_b), 32'(g.mc_done));
            chk({g.tag, ".busy"},    32'(busy_b),    32'(g.busy));
            chk({g.tag, ".timeout"}, 32'(tmo_b),     32'(g.tmo));
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [32-1:0] PC_EXC = 32'hBFC0_0380;
    localparam logic [32-1:0] PC_A   = 32'h8000_0180;
    localparam logic [32-1:0] PC_B   = 32'hBFC0_0200;

    initial begin
        drive(1, 0, 1, 0, '0, 1, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Reset overrides simultaneous stall and flush requests.
        cyc("rst_a", 0, 6'b000000, 0, 32'h0, 0, 0, 0);
        cyc("rst_b", 1, 6'b000000, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("post_rst", 0, 6'b000000, 0, 32'h0, 0, 0, 0);

        // RUN-state stall priority.
        drive(0, 1, 1, 0, '0, 0, 32'h0);
        cyc("id_ex", 0, 6'b001111, 0, 32'h0, 0, 0, 0);
        drive(0, 1, 0, 0, '0, 0, 32'h0);
        cyc("id_only", 0, 6'b000111, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("no_req", 0, 6'b000000, 0, 32'h0, 0, 0, 0);

        // Multi-cycle op, N=5; a second start mid-op is ignored.
        drive(0, 0, 0, 1, 6'd5, 0, 32'h0);
        cyc("mc5_start", 0, 6'b000000, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("mc5_c1", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        drive(0, 0, 0, 1, 6'd1, 0, 32'h0);
        cyc("mc5_c2", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("mc5_c3", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        cyc("mc5_c4", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        cyc("mc5_c5", 0, 6'b001111, 0, 32'h0, 1, 1, 0);
        cyc("mc5_end", 0, 6'b000000, 0, 32'h0, 0, 0, 0);

        // N=0 runs as one cycle.
        drive(0, 0, 0, 1, 6'd0, 0, 32'h0);
        cyc("mc0_start", 0, 6'b000000, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("mc0_c1", 0, 6'b001111, 0, 32'h0, 1, 1, 0);
        cyc("mc0_end", 0, 6'b000000, 0, 32'h0, 0, 0, 0);

        // N=10 aborted by a flush in its third stall cycle.
        drive(0, 0, 0, 1, 6'd10, 0, 32'h0);
        cyc("mc10_start", 0, 6'b000000, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("mc10_c1", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        cyc("mc10_c2", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 1, PC_EXC);
        cyc("mc10_c3", 0, 6'b001111, 0, 32'h0, 0, 1, 0);
        drive(0, 0, 0, 1, 6'd3, 0, 32'h0);
        cyc("abort_flush", 0, 6'b000000, 1, PC_EXC, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("abort_run", 0, 6'b000000, 0, PC_EXC, 0, 0, 0);

        // Restart window with FLUSH_CYCLES=3.
        drive(1, 0, 0, 0, '0, 0, 32'h0);
        cyc("pre_rst2", 0, 6'b000000, 0, PC_EXC, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 1, PC_A);
        cyc("rst2_b", 1, 6'b000000, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("fl_1", 1, 6'b000000, 1, PC_A, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 1, PC_B);
        cyc("fl_2", 1, 6'b000000, 1, PC_A, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("fl_3", 1, 6'b000000, 1, PC_B, 0, 1, 0);
        cyc("fl_4", 1, 6'b000000, 1, PC_B, 0, 1, 0);
        cyc("fl_5", 1, 6'b000000, 1, PC_B, 0, 1, 0);
        cyc("fl_done", 1, 6'b000000, 0, PC_B, 0, 0, 0);

        // Watchdog with TIMEOUT=4: three-cycle request must not trip it.
        drive(0, 1, 0, 0, '0, 0, 32'h0);
        cyc("wd3_1", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        cyc("wd3_2", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        cyc("wd3_3", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("wd3_drop", 1, 6'b000000, 0, PC_B, 0, 0, 0);
        cyc("wd3_idle", 1, 6'b000000, 0, PC_B, 0, 0, 0);
        drive(0, 1, 0, 0, '0, 0, 32'h0);
        cyc("wd4_1", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        cyc("wd4_2", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        cyc("wd4_3", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        cyc("wd4_4", 1, 6'b000111, 0, PC_B, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0, 32'h0);
        cyc("wd4_set", 1, 6'b000000, 0, PC_B, 0, 0, 1);
        cyc("wd4_sticky", 1, 6'b000000, 0, PC_B, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline stall/flush controller for the 5-stage core. It drives the per-stage hold vector into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences multi-cycle EX operations (div, madd) and exception flushes, and supplies the redirect PC. Stage registers consume `stall[i]` as "hold contents" and `flush` as "load NOP/reset values".

Parameters:
- FLUSH_CYCLES, 1, number of cycles `flush` stays high per flush request (1..15).
- TIMEOUT, 255, consecutive stall-request cycles in RUN before `stall_timeout` sets.
- CNT_W, 6, width of the multi-cycle count.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high (`RstEnable`).
- stallreq_id  in  1  ID load-use hazard stall request.
- stallreq_ex  in  1  EX single-cycle stall request.
- ex_mc_start  in  1  one-cycle pulse: EX begins a multi-cycle op.
- ex_mc_cycles  in  CNT_W  op length N, sampled with `ex_mc_start`.
- flush_req  in  1  exception/eret flush request.
- flush_pc  in  32  redirect target, sampled with `flush_req`.
- stall  out  6  hold vector, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  pipeline flush.
- new_pc  out  32  redirect PC, valid while `flush`=1.
- mc_done  out  1  one-cycle pulse in the last multi-cycle stall cycle.
- busy  out  1  high when state != RUN.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- States: RUN, MC_WAIT, FLUSH. Internal counters: `cnt` (CNT_W bits), `fcnt` (4 bits), `wd` (8+ bits, enough for TIMEOUT).
- Reset (`rst`=1 at posedge): state=RUN, cnt=0, fcnt=0, wd=0.
- Outputs on reset: `flush`=0, `new_pc`=`ZeroWord`, `mc_done`=0, `stall_timeout`=0. `stall`=0 combinationally while `rst`=1. Reset overrides every request in the same cycle, including mid-operation.
- `stall` is combinational from state and inputs:
  - RUN: `stallreq_ex` → 6'b001111; else `stallreq_id` → 6'b000111; else 0.
  - MC_WAIT: 6'b001111.
  - FLUSH: 6'b000000.
- `flush`, `new_pc`, `mc_done` and `stall_timeout` are registered. `busy` = (state != RUN).
- Priority at each posedge: rst > `flush_req` > `ex_mc_start` > hold current state.
- `flush_req`=1 in any state: next state FLUSH, `new_pc`<=`flush_pc`, `flush`<=1, fcnt<=FLUSH_CYCLES-1.
  - In FLUSH: if fcnt==0 → RUN and `flush`<=0; else fcnt decrements.
  - A new `flush_req` while in FLUSH restarts the window and relatches `new_pc`.
  - `flush` is high for exactly FLUSH_CYCLES cycles, starting the cycle after the request.
- `ex_mc_start`=1 in RUN: next state MC_WAIT, cnt<=max(N,1)-1. N=0 is treated as N=1.
  - In MC_WAIT: if cnt==0 → RUN; else cnt decrements.
  - `mc_done`<=1 on the edge entering the final MC_WAIT cycle, i.e. high during the cycle where cnt==0 and state==MC_WAIT. For N=1, `mc_done` is high in the single MC_WAIT cycle.
  - Stall 001111 lasts exactly max(N,1) cycles after the start edge. In the start cycle itself, `stall` follows the RUN rules.
- `ex_mc_start` in MC_WAIT or FLUSH is ignored.
- `flush_req` during MC_WAIT aborts the operation: no `mc_done` pulse, cnt cleared.
- Watchdog:
  - In RUN with (`stallreq_id` | `stallreq_ex`)=1, wd increments, saturating at TIMEOUT.
  - Otherwise wd<=0. Leaving RUN also clears wd.
  - When wd reaches TIMEOUT-1 and a request is still present, `stall_timeout`<=1.
  - `stall_timeout` stays set until `rst`. It is informational and does not change `stall`.
- All arithmetic is unsigned. Counters never wrap: cnt stops at 0, wd saturates.

Test Plan:
- Reset with `stallreq_ex`=1, `flush_req`=1 asserted → `stall`=0, `flush`=0, `new_pc`=0, `busy`=0 during and after the reset cycle.
- RUN, `stallreq_id`=1 then `stallreq_ex`=1 same cycle → `stall`=6'b001111 (EX wins). `stallreq_id` alone → 6'b000111. Both deasserted → 0 in the same cycle.
- `ex_mc_start`=1, `ex_mc_cycles`=5 → `stall`=6'b001111 for exactly 5 cycles, `mc_done` high only in the 5th, `busy` high 5 cycles. Repeat with N=0 → 1 cycle, `mc_done` in that cycle.
- MC op N=10, `flush_req`=1 with `flush_pc`=32'hBFC00380 at stall cycle 3 → next cycle `flush`=1, `new_pc`=32'hBFC00380, `stall`=0, no `mc_done`. Returns to RUN after FLUSH_CYCLES=1.
- FLUSH_CYCLES=3: `flush_req` asserted twice, 2 cycles apart (first with PC A, second with PC B) → `flush` high 5 consecutive cycles, `new_pc`=B after the second request.
- TIMEOUT=4, `stallreq_id` held 4 cycles → `stall_timeout`=1 on the following edge and stays 1 after the request drops. Held only 3 cycles then dropped → flag stays 0.
